// File: rtl/screen_phase_compositor.sv
// Game-phase sequencer (TITLE/PLAY/DYING/GAMEOVER) and per-phase pixel-layer
// arbiter feeding a registered r/g/b output toward the VGA DAC.
module screen_phase_compositor #(
  parameter int unsigned DYING_FRAMES    = 120,
  parameter int unsigned OVER_MIN_FRAMES = 60,
  parameter logic [9:0]  BG_COLOR        = 10'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic [9:0]  life_point,
  input  logic [29:0] title_rgb,
  input  logic [29:0] sprite_rgb,
  input  logic [29:0] hud_rgb,
  input  logic [29:0] over_rgb,
  input  logic        title_printed,
  input  logic        sprite_printed,
  input  logic        hud_printed,
  input  logic        over_printed,
  output logic [9:0]  r,
  output logic [9:0]  g,
  output logic [9:0]  b,
  output logic [1:0]  phase,
  output logic        title_en,
  output logic        play_en,
  output logic        over_en,
  output logic        game_restart
);

  typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, GAMEOVER = 2'd3} phase_t;

  localparam logic [7:0] DYING_LAST = 8'(DYING_FRAMES - 1);
  localparam logic [7:0] OVER_MIN   = 8'(OVER_MIN_FRAMES);

  phase_t      state, state_nxt;
  logic        start_d, start_rise, restart_nxt;
  logic [7:0]  frame_cnt;
  logic [29:0] pix_sel;
  logic [9:0]  r_nxt;

  assign start_rise = start_btn & ~start_d;

  always_comb begin
    state_nxt = state;
    case (state)
      TITLE:    if (start_rise) state_nxt = PLAY;
      PLAY:     if (life_point == 10'd0) state_nxt = DYING;
      DYING:    if (frame_tick && frame_cnt == DYING_LAST) state_nxt = GAMEOVER;
      GAMEOVER: if (start_rise && frame_cnt >= OVER_MIN) state_nxt = TITLE;
      default:  state_nxt = TITLE;
    endcase
    restart_nxt = (state == TITLE) && (state_nxt == PLAY);
  end

  // Layer selection uses the current phase register, so a phase change shows
  // up in the pixel registered one cycle after the transition edge.
  always_comb begin
    pix_sel = {3{BG_COLOR}};
    case (state)
      TITLE:       if (title_printed) pix_sel = title_rgb;
      PLAY, DYING: begin
        if (hud_printed)         pix_sel = hud_rgb;
        else if (sprite_printed) pix_sel = sprite_rgb;
      end
      GAMEOVER: begin
        if (over_printed)        pix_sel = over_rgb;
        else if (hud_printed)    pix_sel = hud_rgb;
      end
      default: pix_sel = {3{BG_COLOR}};
    endcase
    r_nxt = pix_sel[29:20];
    if (state == DYING && frame_cnt[3]) r_nxt = 10'h3ff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= TITLE;
      start_d      <= 1'b1;
      frame_cnt    <= 8'd0;
      game_restart <= 1'b0;
      r            <= BG_COLOR;
      g            <= BG_COLOR;
      b            <= BG_COLOR;
    end else begin
      state        <= state_nxt;
      start_d      <= start_btn;
      game_restart <= restart_nxt;
      if (state_nxt != state)                     frame_cnt <= 8'd0;
      else if (frame_tick && frame_cnt != 8'hff)  frame_cnt <= frame_cnt + 8'd1;
      r <= r_nxt;
      g <= pix_sel[19:10];
      b <= pix_sel[9:0];
    end
  end

  assign phase    = state;
  assign title_en = (state == TITLE);
  assign play_en  = (state == PLAY) || (state == DYING);
  assign over_en  = (state == GAMEOVER);

endmodule

// File: tb/tb_screen_phase_compositor.sv
// Scoreboard bench for screen_phase_compositor: expected pixels are queued when
// layer inputs are driven and popped one clock later against r/g/b.
module tb_screen_phase_compositor;

  localparam int unsigned DF = 20;
  localparam int unsigned OM = 5;
  localparam logic [9:0]  BG = 10'h155;

  logic        clk = 1'b0;
  logic        reset_n, frame_tick, start_btn;
  logic [9:0]  life_point;
  logic [29:0] title_rgb, sprite_rgb, hud_rgb, over_rgb;
  logic        title_printed, sprite_printed, hud_printed, over_printed;
  logic [9:0]  r, g, b;
  logic [1:0]  phase;
  logic        title_en, play_en, over_en, game_restart;

  int checks = 0;
  int errors = 0;

  logic [29:0] exp_q[$];
  logic [1:0]  m_phase;
  logic [7:0]  m_cnt;
  logic        m_sd, m_restart;

  screen_phase_compositor #(.DYING_FRAMES(DF), .OVER_MIN_FRAMES(OM), .BG_COLOR(BG)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .life_point(life_point),
    .title_rgb(title_rgb), .sprite_rgb(sprite_rgb), .hud_rgb(hud_rgb), .over_rgb(over_rgb),
    .title_printed(title_printed), .sprite_printed(sprite_printed),
    .hud_printed(hud_printed), .over_printed(over_printed),
    .r(r), .g(g), .b(b), .phase(phase),
    .title_en(title_en), .play_en(play_en), .over_en(over_en), .game_restart(game_restart)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] model_px(input logic [1:0] ph, input logic [7:0] cnt);
    logic [29:0] px;
    px = {BG, BG, BG};
    case (ph)
      2'd0: if (title_printed) px = title_rgb;
      2'd1, 2'd2: begin
        if (hud_printed) px = hud_rgb;
        else if (sprite_printed) px = sprite_rgb;
      end
      default: begin
        if (over_printed) px = over_rgb;
        else if (hud_printed) px = hud_rgb;
      end
    endcase
    if (ph == 2'd2 && cnt[3]) px[29:20] = 10'h3ff;
    return px;
  endfunction

  task automatic model_reset();
    m_phase = 2'd0; m_cnt = 8'd0; m_sd = 1'b1; m_restart = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_layers(input logic tp, input logic sp, input logic hp, input logic op);
    title_printed = tp; sprite_printed = sp; hud_printed = hp; over_printed = op;
  endtask

  // One pixel clock: queue the expected pixel, advance the model, check everything.
  task automatic cycle(input logic ft, input logic sb);
    logic [1:0]  nxt;
    logic        rise;
    logic [29:0] exp_px;
    frame_tick = ft;
    start_btn  = sb;
    exp_q.push_back(model_px(m_phase, m_cnt));
    rise = sb & ~m_sd;
    nxt  = m_phase;
    case (m_phase)
      2'd0: if (rise) nxt = 2'd1;
      2'd1: if (life_point == 10'd0) nxt = 2'd2;
      2'd2: if (ft && m_cnt == 8'(DF - 1)) nxt = 2'd3;
      default: if (rise && m_cnt >= 8'(OM)) nxt = 2'd0;
    endcase
    @(posedge clk); #1;
    m_restart = (m_phase == 2'd0) && (nxt == 2'd1);
    if (nxt != m_phase) m_cnt = 8'd0;
    else if (ft && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
    m_phase = nxt;
    m_sd    = sb;
    frame_tick = 1'b0;
    exp_px = exp_q.pop_front();
    checks++;
    if ({r, g, b} !== exp_px) begin
      errors++;
      $display("FAIL pixel: got %h/%h/%h expected %h/%h/%h", r, g, b,
               exp_px[29:20], exp_px[19:10], exp_px[9:0]);
    end
    checks++;
    if (phase !== m_phase) begin
      errors++;
      $display("FAIL phase: got %0d expected %0d", phase, m_phase);
    end
    checks++;
    if (game_restart !== m_restart) begin
      errors++;
      $display("FAIL game_restart: got %b expected %b", game_restart, m_restart);
    end
    checks++;
    if ({title_en, play_en, over_en} !== {m_phase == 2'd0, m_phase == 2'd1 || m_phase == 2'd2, m_phase == 2'd3}) begin
      errors++;
      $display("FAIL enables: got %b%b%b for phase %0d", title_en, play_en, over_en, m_phase);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_btn = 1'b1; frame_tick = 1'b0; life_point = 10'd10;
    title_rgb = {10'h111, 10'h222, 10'h333}; sprite_rgb = {10'h000, 10'h3ff, 10'h012};
    hud_rgb = {10'h3ff, 10'h000, 10'h000};   over_rgb = {10'h0aa, 10'h0bb, 10'h0cc};
    set_layers(1, 1, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({phase, game_restart, title_en, play_en, over_en} !== 6'b00_0_100) begin
      errors++;
      $display("FAIL reset_state: got phase=%0d restart=%b en=%b%b%b expected 0 0 100",
               phase, game_restart, title_en, play_en, over_en);
    end
    checks++;
    if ({r, g, b} !== {BG, BG, BG}) begin
      errors++;
      $display("FAIL reset_rgb: got %h/%h/%h expected %h", r, g, b, BG);
    end
    reset_n = 1'b1;
    cycle(0, 1);
    cycle(0, 1);
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL held_start: got phase %0d expected 0", phase);
    end
  endtask

  task automatic test_start();
    cycle(0, 0);
    cycle(0, 1);
    checks++;
    if (phase !== 2'd1 || game_restart !== 1'b1) begin
      errors++;
      $display("FAIL start_press: got phase=%0d restart=%b expected 1 1", phase, game_restart);
    end
    cycle(0, 1);
    checks++;
    if (game_restart !== 1'b0) begin
      errors++;
      $display("FAIL restart_pulse: got %b expected 0", game_restart);
    end
    cycle(0, 0);
    cycle(0, 1);
    checks++;
    if (phase !== 2'd1) begin
      errors++;
      $display("FAIL play_ignores_start: got phase %0d expected 1", phase);
    end
  endtask

  task automatic test_play_pixels();
    set_layers(0, 1, 1, 1);
    cycle(0, 0);
    checks++;
    if ({r, g, b} !== {10'h3ff, 10'h000, 10'h000}) begin
      errors++;
      $display("FAIL play_hud: got %h/%h/%h expected 3ff/000/000", r, g, b);
    end
    set_layers(1, 1, 0, 1);
    cycle(0, 0);
    checks++;
    if ({r, g, b} !== {10'h000, 10'h3ff, 10'h012}) begin
      errors++;
      $display("FAIL play_sprite: got %h/%h/%h expected 000/3ff/012", r, g, b);
    end
    set_layers(1, 0, 0, 1);
    cycle(0, 0);
    checks++;
    if ({r, g, b} !== {BG, BG, BG}) begin
      errors++;
      $display("FAIL play_bg: got %h/%h/%h expected %h", r, g, b, BG);
    end
  endtask

  task automatic test_dying();
    set_layers(0, 1, 0, 0);
    life_point = 10'd0;
    cycle(0, 0);
    checks++;
    if (phase !== 2'd2) begin
      errors++;
      $display("FAIL enter_dying: got phase %0d expected 2", phase);
    end
    life_point = 10'd7;
    for (int i = 0; i < 8; i++) cycle(1, i == 3);
    cycle(0, 0);
    checks++;
    if (r !== 10'h3ff || g !== 10'h3ff || b !== 10'h012) begin
      errors++;
      $display("FAIL dying_red: got %h/%h/%h expected 3ff/3ff/012", r, g, b);
    end
    for (int i = 8; i < DF - 1; i++) cycle(1, 0);
    checks++;
    if (phase !== 2'd2) begin
      errors++;
      $display("FAIL dying_early: got phase %0d expected 2", phase);
    end
    cycle(1, 0);
    checks++;
    if (phase !== 2'd3) begin
      errors++;
      $display("FAIL dying_end: got phase %0d expected 3", phase);
    end
  endtask

  task automatic test_gameover();
    set_layers(1, 1, 1, 1);
    cycle(0, 0);
    set_layers(1, 1, 1, 0);
    for (int i = 0; i < OM - 1; i++) cycle(1, 0);
    cycle(0, 1);
    checks++;
    if (phase !== 2'd3) begin
      errors++;
      $display("FAIL early_press: got phase %0d expected 3", phase);
    end
    cycle(1, 1);
    checks++;
    if (phase !== 2'd3) begin
      errors++;
      $display("FAIL press_not_queued: got phase %0d expected 3", phase);
    end
    cycle(0, 0);
    cycle(0, 1);
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL over_to_title: got phase %0d expected 0", phase);
    end
  endtask

  task automatic test_title_ignore();
    set_layers(0, 1, 1, 1);
    cycle(0, 0);
    cycle(0, 0);
    checks++;
    if ({r, g, b} !== {BG, BG, BG}) begin
      errors++;
      $display("FAIL title_ignore: got %h/%h/%h expected %h", r, g, b, BG);
    end
  endtask

  task automatic test_async_reset();
    life_point = 10'd9;
    cycle(0, 0);
    cycle(0, 1);
    life_point = 10'd0;
    set_layers(0, 0, 1, 0);
    cycle(0, 0);
    cycle(1, 0);
    cycle(1, 0);
    start_btn = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({phase, game_restart, title_en, play_en, over_en} !== 6'b00_0_100 || {r, g, b} !== {BG, BG, BG}) begin
      errors++;
      $display("FAIL async_reset: got phase=%0d restart=%b en=%b%b%b rgb=%h/%h/%h",
               phase, game_restart, title_en, play_en, over_en, r, g, b);
    end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    life_point = 10'd9;
    set_layers(1, 1, 1, 1);
    cycle(0, 0);
    checks++;
    if ({r, g, b} !== {10'h111, 10'h222, 10'h333}) begin
      errors++;
      $display("FAIL first_title_px: got %h/%h/%h expected 111/222/333", r, g, b);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_play_pixels();
    test_dying();
    test_gameover();
    test_title_ignore();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
